// File: rtl/axi4_burst_reg_slave.sv
// axi4_burst_reg_slave: AXI4 burst slave (INCR/FIXED/WRAP, byte strobes, ID-tagged responses) over a 32-bit register bank.
// Optional feature macro AXI_SLV_ADDR_CHECK_EN: beats beyond C_NUM_WORDS are dropped and flagged SLVERR instead of aliasing.
module axi4_burst_reg_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_WORDS        = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    localparam int IW = $clog2(C_NUM_WORDS);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    // AxSIZE is ignored: every beat is a full 4-byte word
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len, input logic [1:0] burst);
        logic [AW-1:0] mask;
        logic          wrap_ok;
        mask    = AW'({len, 2'b11});
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == BURST_FIXED) ? a :
               (burst == BURST_WRAP && wrap_ok) ? ((a & ~mask) | ((a + AW'(4)) & mask)) :
               a + AW'(4);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
        return a[IW+1:2];
    endfunction

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_NUM_WORDS];

    logic [1:0]                  w_state;
    logic                        aw_ready;
    logic [AW-1:0]               w_addr;
    logic [7:0]                  w_len;
    logic [7:0]                  w_beat;
    logic [1:0]                  w_burst;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id;
    logic                        w_err;
    logic                        b_valid;
    logic [1:0]                  b_resp;
    logic [C_S_AXI_ID_WIDTH-1:0] b_id;
    logic                        w_last;
    logic                        w_err_next;
    logic                        w_oob;

    logic                        r_state;
    logic                        ar_ready;
    logic [AW-1:0]               r_addr;
    logic [7:0]                  r_len;
    logic [7:0]                  r_beat;
    logic [1:0]                  r_burst;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id;
    logic                        r_valid;
    logic                        r_last;
    logic [1:0]                  r_resp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data;
    logic [AW-1:0]               r_load_addr;
    logic                        r_oob;
    logic                        unused;

    assign unused = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

    // The beat counter, not WLAST, ends the burst; a disagreeing WLAST only taints the response
    assign w_last      = (w_beat == w_len);
    assign w_err_next  = w_err | w_oob | (S_AXI_WLAST != w_last);
    // Address of the beat about to be presented: the AR address on acceptance, else the successor
    assign r_load_addr = (r_state == R_IDLE) ? S_AXI_ARADDR : next_addr(r_addr, r_len, r_burst);

`ifdef AXI_SLV_ADDR_CHECK_EN
    assign w_oob = |(w_addr[AW-1:2] >> IW);
    assign r_oob = |(r_load_addr[AW-1:2] >> IW);
`else
    assign w_oob = 1'b0;
    assign r_oob = 1'b0;
`endif

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = (w_state == W_DATA);
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_BID     = b_id;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RLAST   = r_last;
    assign S_AXI_RRESP   = r_resp;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RID     = r_id;

    // Write FSM: capture AW, absorb one beat per cycle into the register bank, then hold B until taken
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_addr   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_burst  <= '0;
            w_id     <= '0;
            w_err    <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            b_id     <= '0;
            for (int i = 0; i < C_NUM_WORDS; i++) mem[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID && aw_ready) begin
                        aw_ready <= 1'b0;
                        w_addr   <= S_AXI_AWADDR;
                        w_len    <= S_AXI_AWLEN;
                        w_burst  <= S_AXI_AWBURST;
                        w_id     <= S_AXI_AWID;
                        w_beat   <= '0;
                        w_err    <= 1'b0;
                        w_state  <= W_DATA;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        if (!w_oob) begin
                            for (int b = 0; b < NB; b++)
                                if (S_AXI_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                        end
                        w_addr <= next_addr(w_addr, w_len, w_burst);
                        w_beat <= w_beat + 8'd1;
                        w_err  <= w_err_next;
                        if (w_last) begin
                            b_valid <= 1'b1;
                            b_resp  <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                            b_id    <= w_id;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: register each beat from the bank and hold it until the master takes it
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_burst  <= '0;
            r_id     <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_resp   <= RESP_OKAY;
            r_data   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID && ar_ready) begin
                        ar_ready <= 1'b0;
                        r_addr   <= S_AXI_ARADDR;
                        r_len    <= S_AXI_ARLEN;
                        r_burst  <= S_AXI_ARBURST;
                        r_id     <= S_AXI_ARID;
                        r_beat   <= '0;
                        r_valid  <= 1'b1;
                        r_last   <= (S_AXI_ARLEN == 8'd0);
                        r_data   <= r_oob ? '0 : mem[word_idx(r_load_addr)];
                        r_resp   <= r_oob ? RESP_SLVERR : RESP_OKAY;
                        r_state  <= R_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            ar_ready <= 1'b1;
                            r_state  <= R_IDLE;
                        end else begin
                            r_addr <= r_load_addr;
                            r_beat <= r_beat + 8'd1;
                            r_last <= (r_beat + 8'd1 == r_len);
                            r_data <= r_oob ? '0 : mem[word_idx(r_load_addr)];
                            r_resp <= r_oob ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_burst_reg_slave.sv
// tb_axi4_burst_reg_slave: directed bench for axi4_burst_reg_slave with an 8-word bank (expectations follow AXI_SLV_ADDR_CHECK_EN).
module tb_axi4_burst_reg_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        awid, awvalid, awready;
    logic [5:0]  awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bid, bvalid, bready;
    logic [1:0]  bresp;
    logic        arid, arvalid, arready;
    logic [5:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rid, rlast, rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int tests = 0;
    int fails = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic        rlbuf [16];
    logic [1:0]  rrbuf [16];
    logic        rid_got;
    int          rcount;
    logic [1:0]  got_bresp;
    logic        got_bid;

    axi4_burst_reg_slave #(
        .C_S_AXI_ID_WIDTH(1), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .C_NUM_WORDS(8)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_aw(input logic id, input logic [5:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
        while (!awready && n < 20) begin @(posedge clk); #1; n++; end
        if (!awready) begin
            tests++; fails++;
            $display("FAIL aw_handshake: awready=%0b after %0d cycles, required 1", awready, n);
        end else begin
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic id, input logic [5:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        if (!arready) begin
            tests++; fails++;
            $display("FAIL ar_handshake: arready=%0b after %0d cycles, required 1", arready, n);
        end else begin
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
    endtask

    task automatic write_burst(input logic id, input logic [5:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic bad_last);
        int n;
        send_aw(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == int'(len)) ^ bad_last;
            n = 0;
            while (!wready && n < 20) begin @(posedge clk); #1; n++; end
            if (!wready) begin
                tests++; fails++;
                $display("FAIL w_handshake: wready=%0b at beat %0d, required 1", wready, i);
                break;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1; n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bvalid) begin
            tests++; fails++;
            $display("FAIL b_handshake: bvalid=%0b after %0d cycles, required 1", bvalid, n);
            got_bresp = 2'bxx; got_bid = 1'bx;
        end else begin
            got_bresp = bresp; got_bid = bid;
            @(posedge clk); #1;
        end
        bready = 1'b0;
    endtask

    task automatic read_burst(input logic id, input logic [5:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int  n = 0;
        logic done = 1'b0;
        rcount = 0;
        send_ar(id, addr, len, burst);
        rready = 1'b1;
        while (!done && n < 60) begin
            if (rvalid && rcount < 16) begin
                rbuf[rcount] = rdata; rlbuf[rcount] = rlast; rrbuf[rcount] = rresp; rid_got = rid;
                rcount++;
                done = rlast;
            end
            @(posedge clk); #1; n++;
        end
        rready = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL r_burst: no RLAST after %0d cycles, %0d beats seen", n, rcount);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rdata, rresp, rid} !== 44'd0) begin
            fails++;
            $display("FAIL reset_outputs: got aw=%0b w=%0b bv=%0b br=%0h bid=%0b ar=%0b rv=%0b rl=%0b rd=%0h rr=%0h rid=%0b, required all 0",
                     awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rdata, rresp, rid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({awready, arready} !== 2'b11) begin
            fails++;
            $display("FAIL ready_after_reset: awready=%0b arready=%0b, required 1 1", awready, arready);
        end
        read_burst(1'b0, 6'h00, 8'd0, 2'b01);
        tests++;
        if (rbuf[0] !== 32'h0) begin
            fails++;
            $display("FAIL reset_reg0: got %h, required 00000000", rbuf[0]);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        write_burst(1'b1, 6'h00, 8'd7, 2'b01, 1'b0);
        tests++;
        if (got_bresp !== 2'b00 || got_bid !== 1'b1) begin
            fails++;
            $display("FAIL incr_b: bresp=%0h bid=%0b, required 0 1", got_bresp, got_bid);
        end
        tests++;
        if (awready !== 1'b1) begin
            fails++;
            $display("FAIL aw_back_to_back: awready=%0b cycle after B, required 1", awready);
        end
        read_burst(1'b1, 6'h00, 8'd7, 2'b01);
        tests++;
        if (rcount != 8) begin
            fails++;
            $display("FAIL incr_beats: got %0d beats, required 8", rcount);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rbuf[i] !== 32'(i + 1) || rlbuf[i] !== (i == 7) || rrbuf[i] !== 2'b00) begin
                fails++;
                $display("FAIL incr_beat%0d: data=%h last=%0b resp=%0h, required %h %0b 0",
                         i, rbuf[i], rlbuf[i], rrbuf[i], 32'(i + 1), (i == 7));
            end
        end
        tests++;
        if (rid_got !== 1'b1 || arready !== 1'b1) begin
            fails++;
            $display("FAIL incr_rid_ar: rid=%0b arready=%0b, required 1 1", rid_got, arready);
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
        write_burst(1'b0, 6'h04, 8'd0, 2'b01, 1'b0);
        wbuf[0] = 32'h11223344; sbuf[0] = 4'h5;
        write_burst(1'b0, 6'h04, 8'd0, 2'b01, 1'b0);
        read_burst(1'b0, 6'h04, 8'd0, 2'b01);
        tests++;
        if (rbuf[0] !== 32'hAA22CC44 || rlbuf[0] !== 1'b1) begin
            fails++;
            $display("FAIL strobe: data=%h last=%0b, required aa22cc44 1", rbuf[0], rlbuf[0]);
        end
    endtask

    task automatic test_wrap_fixed();
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        write_burst(1'b0, 6'h18, 8'd3, 2'b10, 1'b0);
        read_burst(1'b0, 6'h10, 8'd3, 2'b01);
        tests++;
        if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3]} !== {32'hC, 32'hD, 32'hA, 32'hB}) begin
            fails++;
            $display("FAIL wrap4: got %h %h %h %h, required c d a b", rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
        end
        wbuf[0] = 32'h31; wbuf[1] = 32'h32; wbuf[2] = 32'h33;
        write_burst(1'b0, 6'h08, 8'd2, 2'b00, 1'b0);
        read_burst(1'b0, 6'h08, 8'd1, 2'b00);
        tests++;
        if (rbuf[0] !== 32'h33 || rbuf[1] !== 32'h33 || rlbuf[1] !== 1'b1) begin
            fails++;
            $display("FAIL fixed: got %h %h last=%0b, required 33 33 1", rbuf[0], rbuf[1], rlbuf[1]);
        end
        wbuf[0] = 32'h41; wbuf[1] = 32'h42;
        write_burst(1'b0, 6'h0C, 8'd1, 2'b10, 1'b0);
        read_burst(1'b0, 6'h08, 8'd1, 2'b01);
        tests++;
        if (rbuf[0] !== 32'h42 || rbuf[1] !== 32'h41) begin
            fails++;
            $display("FAIL wrap2: got %h %h, required 42 41", rbuf[0], rbuf[1]);
        end
    endtask

    task automatic test_read_stall();
        logic [36:0] snap;
        logic        held = 1'b0;
        int          k = 0;
        int          n = 0;
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h100 + 32'(i); sbuf[i] = 4'hF; end
        write_burst(1'b0, 6'h00, 8'd7, 2'b01, 1'b0);
        send_ar(1'b1, 6'h00, 8'd7, 2'b01);
        while (k < 8 && n < 100) begin
            rready = (n % 4 == 0) || (n % 4 == 3);
            if (held) begin
                tests++;
                if ({rvalid, rdata, rlast, rresp, rid} !== snap) begin
                    fails++;
                    $display("FAIL stall_hold beat %0d: got %h, required %h", k, {rvalid, rdata, rlast, rresp, rid}, snap);
                end
            end
            if (rvalid && rready) begin
                tests++;
                if (rdata !== 32'h100 + 32'(k) || rlast !== (k == 7) || rid !== 1'b1 || rresp !== 2'b00) begin
                    fails++;
                    $display("FAIL stall_beat%0d: data=%h last=%0b rid=%0b resp=%0h, required %h %0b 1 0",
                             k, rdata, rlast, rid, rresp, 32'h100 + 32'(k), (k == 7));
                end
                k++;
                held = 1'b0;
            end else if (rvalid) begin
                snap = {rvalid, rdata, rlast, rresp, rid};
                held = 1'b1;
            end
            @(posedge clk); #1; n++;
        end
        rready = 1'b0;
        tests++;
        if (k != 8) begin
            fails++;
            $display("FAIL stall_count: got %0d beats, required 8", k);
        end
    endtask

    task automatic test_wlast_mismatch();
        wbuf[0] = 32'h77; wbuf[1] = 32'h88; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        write_burst(1'b1, 6'h08, 8'd1, 2'b01, 1'b1);
        tests++;
        if (got_bresp !== 2'b10 || got_bid !== 1'b1) begin
            fails++;
            $display("FAIL wlast_bresp: bresp=%0h bid=%0b, required 2 1", got_bresp, got_bid);
        end
        read_burst(1'b0, 6'h08, 8'd1, 2'b01);
        tests++;
        if (rbuf[0] !== 32'h77 || rbuf[1] !== 32'h88) begin
            fails++;
            $display("FAIL wlast_data: got %h %h, required 77 88", rbuf[0], rbuf[1]);
        end
        wbuf[0] = 32'h99;
        write_burst(1'b0, 6'h08, 8'd0, 2'b01, 1'b0);
        tests++;
        if (got_bresp !== 2'b00) begin
            fails++;
            $display("FAIL wlast_recover: bresp=%0h, required 0", got_bresp);
        end
    endtask

    task automatic test_addr_range();
        logic [1:0]  exp_b;
        logic [31:0] exp_w0, exp_w1, exp_r2, exp_r3;
        logic [1:0]  exp_rr;
`ifdef AXI_SLV_ADDR_CHECK_EN
        exp_b = 2'b10; exp_w0 = 32'h55; exp_w1 = 32'h66; exp_r2 = 32'h0; exp_r3 = 32'h0; exp_rr = 2'b10;
`else
        exp_b = 2'b00; exp_w0 = 32'hE2; exp_w1 = 32'hE3; exp_r2 = 32'hE2; exp_r3 = 32'hE3; exp_rr = 2'b00;
`endif
        wbuf[0] = 32'h55; wbuf[1] = 32'h66; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        write_burst(1'b0, 6'h00, 8'd1, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hE0 + 32'(i); sbuf[i] = 4'hF; end
        write_burst(1'b0, 6'h18, 8'd3, 2'b01, 1'b0);
        tests++;
        if (got_bresp !== exp_b) begin
            fails++;
            $display("FAIL range_bresp: bresp=%0h, required %0h", got_bresp, exp_b);
        end
        read_burst(1'b0, 6'h00, 8'd1, 2'b01);
        tests++;
        if (rbuf[0] !== exp_w0 || rbuf[1] !== exp_w1) begin
            fails++;
            $display("FAIL range_alias: words0,1 %h %h, required %h %h", rbuf[0], rbuf[1], exp_w0, exp_w1);
        end
        read_burst(1'b0, 6'h18, 8'd3, 2'b01);
        tests++;
        if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3]} !== {32'hE0, 32'hE1, exp_r2, exp_r3}
            || {rrbuf[0], rrbuf[1], rrbuf[2], rrbuf[3]} !== {2'b00, 2'b00, exp_rr, exp_rr}) begin
            fails++;
            $display("FAIL range_read: data %h %h %h %h resp %0h %0h %0h %0h, required e0 e1 %h %h resp 0 0 %0h %0h",
                     rbuf[0], rbuf[1], rbuf[2], rbuf[3], rrbuf[0], rrbuf[1], rrbuf[2], rrbuf[3],
                     exp_r2, exp_r3, exp_rr, exp_rr);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic saw_b = 1'b0;
        send_aw(1'b1, 6'h00, 8'd7, 2'b01);
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1; wdata = 32'h200 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rdata, rresp, rid} !== 44'd0) begin
            fails++;
            $display("FAIL midreset_outputs: aw=%0b w=%0b bv=%0b br=%0h bid=%0b ar=%0b rv=%0b, required all 0",
                     awready, wready, bvalid, bresp, bid, arready, rvalid);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid) saw_b = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if (saw_b !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_b: bvalid seen=%0b, required 0", saw_b);
        end
        read_burst(1'b0, 6'h00, 8'd1, 2'b01);
        tests++;
        if (rbuf[0] !== 32'h0 || rbuf[1] !== 32'h0) begin
            fails++;
            $display("FAIL midreset_cleared: got %h %h, required 0 0", rbuf[0], rbuf[1]);
        end
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h300 + 32'(i); sbuf[i] = 4'hF; end
        write_burst(1'b0, 6'h00, 8'd7, 2'b01, 1'b0);
        tests++;
        if (got_bresp !== 2'b00 || got_bid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_fresh_b: bresp=%0h bid=%0b, required 0 0", got_bresp, got_bid);
        end
        read_burst(1'b0, 6'h00, 8'd7, 2'b01);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rbuf[i] !== 32'h300 + 32'(i)) begin
                fails++;
                $display("FAIL midreset_fresh_beat%0d: got %h, required %h", i, rbuf[i], 32'h300 + 32'(i));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        test_reset();
        test_incr();
        test_strobe();
        test_wrap_fixed();
        test_read_stall();
        test_wlast_mismatch();
        test_addr_range();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
